// File: rtl/sequential_multiplier.sv
// Iterative shift-and-add multiplier with valid/ready handshake on both sides
// and a metadata word that travels unchanged alongside each operation.
// One product every ceil(width/bits_per_step) cycles plus one DONE cycle.
// Signed mode multiplies magnitudes and applies the sign at the end.
module sequential_multiplier #(
    parameter int                width            = 32,
    parameter int                bits_per_step    = 1,
    parameter bit                is_signed        = 1'b0,
    parameter type               metadata_type    = logic,
    parameter metadata_type      default_metadata = '0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 ivalid,
    output logic                 iready,
    input  metadata_type         imeta,
    input  logic [width-1:0]     lhs,
    input  logic [width-1:0]     rhs,
    output logic                 ovalid,
    input  logic                 oready,
    output metadata_type         ometa,
    output logic [2*width-1:0]   res
);

    // Number of iterations; the multiplier register is padded up to a whole
    // number of digits so the final digit sees zeros in its upper bits.
    localparam int STEPS = (width + bits_per_step - 1) / bits_per_step;
    localparam int PADW  = STEPS * bits_per_step;
    localparam int PW    = 2 * width;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(STEPS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Magnitude of an operand. The most negative value maps onto the
    // unsigned value 2^(width-1), which is exactly its magnitude.
    function automatic logic [width-1:0] magnitude(input logic [width-1:0] value);
        logic [width-1:0] mag;
        if (is_signed && value[width-1]) begin
            mag = ~value + width'(1'b1);
        end else begin
            mag = value;
        end
        return mag;
    endfunction

    // Multiplicand times one multiplier digit, built from shifted adds so no
    // hard multiplier is inferred. Bits shifted past the product width can
    // never contribute to a product that fits, so truncation is harmless.
    function automatic logic [PW-1:0] partial_product(input logic [PW-1:0]            mcand,
                                                      input logic [bits_per_step-1:0] digit);
        logic [PW-1:0] sum;
        sum = '0;
        for (int i = 0; i < bits_per_step; i++) begin
            if (digit[i]) begin
                sum = sum + (mcand << i);
            end else begin
                sum = sum;
            end
        end
        return sum;
    endfunction

    state_t             state_q;
    logic [CW-1:0]      count_q;
    logic [PW-1:0]      mcand_q;
    logic [PADW-1:0]    mplier_q;
    logic [PW-1:0]      acc_q;
    logic               sign_q;
    metadata_type       meta_q;
    logic               ovalid_q;
    metadata_type       ometa_q;
    logic [PW-1:0]      res_q;

    logic               iready_s;
    logic               accept_s;
    logic [width-1:0]   lhs_mag_s;
    logic [width-1:0]   rhs_mag_s;
    logic               sign_s;
    logic [PW-1:0]      acc_d;
    logic [PW-1:0]      product_d;
    logic [PW-1:0]      mcand_d;
    logic [PADW-1:0]    mplier_d;

    // Handshake: ready when idle, or when the held product leaves this cycle.
    always_comb begin
        iready_s = 1'b0;
        if (reset) begin
            iready_s = 1'b0;
        end else if (state_q == ST_IDLE) begin
            iready_s = 1'b1;
        end else if (state_q == ST_DONE) begin
            iready_s = oready;
        end else begin
            iready_s = 1'b0;
        end
        accept_s = ivalid && iready_s;
    end

    // Operand conditioning at accept: magnitudes and latched result sign.
    always_comb begin
        lhs_mag_s = magnitude(lhs);
        rhs_mag_s = magnitude(rhs);
        sign_s    = 1'b0;
        if (is_signed) begin
            sign_s = lhs[width-1] ^ rhs[width-1];
        end else begin
            sign_s = 1'b0;
        end
    end

    // One iteration of the datapath and the signed final result.
    always_comb begin
        acc_d     = acc_q + partial_product(mcand_q, mplier_q[bits_per_step-1:0]);
        mcand_d   = mcand_q << bits_per_step;
        mplier_d  = mplier_q >> bits_per_step;
        product_d = acc_d;
        if (sign_q) begin
            product_d = ~acc_d + PW'(1'b1);
        end else begin
            product_d = acc_d;
        end
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            sign_q   <= 1'b0;
            meta_q   <= default_metadata;
            ovalid_q <= 1'b0;
            ometa_q  <= default_metadata;
            res_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_q <= ST_IDLE;
                end
                ST_BUSY: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_d;
                    mplier_q <= mplier_d;
                    if (count_q == '0) begin
                        state_q  <= ST_DONE;
                        res_q    <= product_d;
                        ometa_q  <= meta_q;
                        ovalid_q <= 1'b1;
                    end else begin
                        count_q <= count_q - CW'(1'b1);
                    end
                end
                ST_DONE: begin
                    if (oready) begin
                        state_q  <= ST_IDLE;
                        ovalid_q <= 1'b0;
                    end else begin
                        state_q  <= ST_DONE;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    ovalid_q <= 1'b0;
                end
            endcase

            // A new operation overrides the transition chosen above; this
            // only happens from IDLE or from DONE while the product leaves.
            if (accept_s) begin
                state_q  <= ST_BUSY;
                count_q  <= LAST_COUNT;
                acc_q    <= '0;
                mcand_q  <= PW'(lhs_mag_s);
                mplier_q <= PADW'(rhs_mag_s);
                sign_q   <= sign_s;
                meta_q   <= imeta;
                ovalid_q <= 1'b0;
            end
        end
    end

    assign iready = iready_s;
    assign ovalid = ovalid_q;
    assign ometa  = ometa_q;
    assign res    = res_q;

endmodule
